// File: rtl/part_select_writer.sv
// -----------------------------------------------------------------------------
// part_select_writer
//
// Writes a variable-width bit field into a packed register array. The field
// is anchored at req_base and grows upward (req_dir=0, base +: len) or
// downward (req_dir=1, base -: len). A field lying inside one word is
// written in a single WR_LO cycle. A field crossing a word boundary is
// written in two steps: WR_LO writes the low word and WR_HI writes the high
// word. Illegal requests are rejected with done+err and change nothing.
//
// Parameters
//   WORD_W    bits per packed word
//   NWORDS    number of packed words (TOTAL = WORD_W*NWORDS)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req_valid  write request valid
//   req_ready  request accepted when req_valid && req_ready
//   req_base   anchor bit index
//   req_dir    0 = ascending, 1 = descending from req_base
//   req_len    field width in bits (1..WORD_W)
//   req_data   field data; bit 0 lands on the lowest addressed bit
//   clr        synchronous clear of all storage (honoured only in IDLE)
//   mem_o      packed storage; word w = mem_o[w*WORD_W +: WORD_W]
//   busy       high in any state other than IDLE
//   done       one-cycle completion pulse
//   err        qualifies done: request rejected, nothing written
//
// Optional feature (macro PART_SELECT_WRITER_READBACK_EN)
//   rd_idx     word index to read back
//   rd_word    registered copy of word rd_idx as of the previous edge,
//              including any write made on that edge; 0 for rd_idx >= NWORDS
// -----------------------------------------------------------------------------
module part_select_writer #(
    parameter int unsigned WORD_W = 8,
    parameter int unsigned NWORDS = 4,
    localparam int unsigned TOTAL = WORD_W * NWORDS,
    localparam int unsigned AW    = $clog2(TOTAL),
    localparam int unsigned LW    = $clog2(WORD_W) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [AW-1:0]     req_base,
    input  logic              req_dir,
    input  logic [LW-1:0]     req_len,
    input  logic [WORD_W-1:0] req_data,
    input  logic              clr,
    output logic [TOTAL-1:0]  mem_o,
    output logic              busy,
    output logic              done,
    output logic              err
`ifdef PART_SELECT_WRITER_READBACK_EN
    ,
    input  logic [$clog2(NWORDS)-1:0] rd_idx,
    output logic [WORD_W-1:0]         rd_word
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        WR_LO,
        WR_HI
    } state_t;

    // Two extra bits let base+1, lo+len-1 and TOTAL be compared without
    // wrapping, and make descending underflow visible before truncation.
    localparam int unsigned EW = AW + 2;

    // Mask covering word 0; shifted up to select any other word.
    localparam logic [TOTAL-1:0] WMASK0 = (TOTAL'(1) << WORD_W) - TOTAL'(1);

    state_t              state;
    logic [TOTAL-1:0]    mem_q;
    logic [TOTAL-1:0]    mem_next;
    logic [EW-1:0]       lo_q;
    logic [EW-1:0]       hi_q;
    logic [WORD_W-1:0]   data_q;
    logic [LW-1:0]       len_q;

    logic [EW-1:0]       base_x;
    logic [EW-1:0]       len_x;
    logic [EW-1:0]       lo_x;
    logic [EW-1:0]       hi_x;
    logic                req_illegal;

    int unsigned         lo_wbase;
    int unsigned         hi_wbase;
    logic                same_word;
    logic [TOTAL-1:0]    field_mask;
    logic [TOTAL-1:0]    field_data;
    logic [TOTAL-1:0]    word_mask;
    logic [TOTAL-1:0]    wr_mask;

    // Request decode on the live inputs; used only at acceptance.
    always_comb begin
        base_x      = EW'(req_base);
        len_x       = EW'(req_len);
        lo_x        = req_dir ? (base_x - len_x + EW'(1)) : base_x;
        hi_x        = lo_x + len_x - EW'(1);
        req_illegal = (req_len == '0)
                   || (len_x > EW'(WORD_W))
                   || (req_dir && ((base_x + EW'(1)) < len_x))
                   || (hi_x >= EW'(TOTAL));
    end

    // Write datapath. The field mask/data are built in TOTAL width so any
    // bits shifted past the top are discarded instead of wrapping into
    // word 0. Each write state then restricts the field to its own word.
    always_comb begin
        lo_wbase   = (32'(lo_q) / WORD_W) * WORD_W;
        hi_wbase   = (32'(hi_q) / WORD_W) * WORD_W;
        same_word  = (lo_wbase == hi_wbase);
        field_mask = ((TOTAL'(1) << len_q) - TOTAL'(1)) << lo_q;
        field_data = TOTAL'(data_q) << lo_q;
        word_mask  = (state == WR_HI) ? (WMASK0 << hi_wbase)
                                      : (WMASK0 << lo_wbase);
        wr_mask    = field_mask & word_mask;

        mem_next = mem_q;
        case (state)
            IDLE: begin
                if (clr) begin
                    mem_next = '0;
                end
            end
            WR_LO, WR_HI: begin
                mem_next = (mem_q & ~wr_mask) | (field_data & wr_mask);
            end
            default: begin
                mem_next = mem_q;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            mem_q  <= '0;
            lo_q   <= '0;
            hi_q   <= '0;
            data_q <= '0;
            len_q  <= '0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            mem_q <= mem_next;
            done  <= 1'b0;
            err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        if (req_illegal) begin
                            done <= 1'b1;
                            err  <= 1'b1;
                        end else begin
                            lo_q   <= lo_x;
                            hi_q   <= hi_x;
                            data_q <= req_data;
                            len_q  <= req_len;
                            state  <= WR_LO;
                        end
                    end
                end
                WR_LO: begin
                    if (same_word) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end else begin
                        state <= WR_HI;
                    end
                end
                WR_HI: begin
                    state <= IDLE;
                    done  <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef PART_SELECT_WRITER_READBACK_EN
    // Reads from mem_next so the word reflects the write on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_word <= '0;
        end else if (32'(rd_idx) < NWORDS) begin
            rd_word <= mem_next[32'(rd_idx) * WORD_W +: WORD_W];
        end else begin
            rd_word <= '0;
        end
    end
`endif

    assign req_ready = (state == IDLE) && !clr;
    assign busy      = (state != IDLE);
    assign mem_o     = mem_q;

endmodule

// File: doc/part_select_writer.md
PART_SELECT_WRITER -- requirements
Module: part_select_writer

Interface
REQ-001 Parameter WORD_W, default 8, bits per packed word.
REQ-002 Parameter NWORDS, default 4, number of packed words; TOTAL = WORD_W*NWORDS.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 req_valid  input  1  write request valid.
REQ-006 req_ready  output  1  request accepted when req_valid && req_ready.
REQ-007 req_base  input  $clog2(TOTAL)  anchor bit index.
REQ-008 req_dir  input  1  0 = ascending (base +: len), 1 = descending (base -: len).
REQ-009 req_len  input  $clog2(WORD_W)+1  field width in bits.
REQ-010 req_data  input  WORD_W  field data; bit 0 lands on the lowest addressed bit.
REQ-011 clr  input  1  synchronous clear of all storage.
REQ-012 mem_o  output  TOTAL  packed storage; word w = mem_o[w*WORD_W +: WORD_W].
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 done  output  1  one-cycle completion pulse.
REQ-015 err  output  1  qualifies done; request rejected, nothing written.

Function
REQ-016 FSM states SHALL be IDLE, WR_LO, WR_HI; req_ready = (state==IDLE) && !clr.
REQ-017 On acceptance, the block SHALL latch lo = (dir ? base-len+1 : base), hi = lo+len-1, the data and the len.
REQ-018 The request SHALL be illegal when len==0, len>WORD_W, descending with base+1<len, or hi>=TOTAL.
- Illegal request: go straight back to IDLE; done=err=1 in the next cycle; storage unchanged.
REQ-019 Legal request: IDLE->WR_LO; at the end of WR_LO, write bits lo..min(hi, word end of lo).
REQ-020 If lo/WORD_W == hi/WORD_W, WR_LO->IDLE; otherwise WR_LO->WR_HI, which writes the remaining bits of word hi/WORD_W, then ->IDLE.
REQ-021 done (err=0) SHALL pulse in the first IDLE cycle after the final write edge; the block accepts a new request in that same cycle.
- Latency: 2 cycles accept-to-done for a single word, 3 cycles for a spanning write.
REQ-022 Bits outside lo..hi SHALL remain unchanged; req_data bits at positions >= len are ignored.
REQ-023 clr high in IDLE SHALL zero all storage at the next edge.
- clr blocks acceptance, so a simultaneous clr and request means clr wins and the request stays pending.
- clr outside IDLE SHALL be ignored.
REQ-024 A write to the maximum legal range (hi = TOTAL-1) SHALL NOT wrap into word 0.

Reset
REQ-025 rst_n low SHALL immediately force state=IDLE, storage=0, done=0, err=0, busy=0.
REQ-026 Reset mid-operation (WR_LO/WR_HI) SHALL abort the write with no partial update surviving and no done pulse.

Configuration
REQ-027 Macro PART_SELECT_WRITER_READBACK_EN defined:
- adds input rd_idx ($clog2(NWORDS)) and output rd_word (WORD_W);
- rd_word is registered and equals word rd_idx as of the previous edge, including that edge's write;
- rd_word resets to 0, and rd_idx >= NWORDS returns 0.
REQ-028 Macro undefined: rd_idx/rd_word ports and their logic SHALL be absent; all other behaviour is identical.

Verification
REQ-029 Reset, then request base=3 dir=0 len=1 data=1 -> done after 2 cycles, mem_o=32'h0000_0008.
REQ-030 From zero, base=10 dir=0 len=4 data=4'hF -> mem_o=32'h0000_3C00 at done, 2-cycle latency.
REQ-031 From zero, base=13 dir=1 len=8 data=8'hA5 -> lo=6, spans words 0/1, done after 3 cycles, mem_o=32'h0000_2940.
REQ-032 Illegal requests -> done=err=1, mem_o unchanged:
- base=2 dir=1 len=4 (underflow);
- base=30 dir=0 len=4 (overflow);
- len=0.
REQ-033 Clear and reset:
- clr=1 together with req_valid=1 in IDLE -> mem_o=0, request accepted only after clr falls.
- rst_n pulsed low during WR_HI -> mem_o=0, no done.
REQ-034 With PART_SELECT_WRITER_READBACK_EN defined: after REQ-031, rd_idx=1 -> rd_word=8'h29 one cycle later.
